// File: rtl/ao4_stim_checker.sv
// Stimulus generator and cycle-accurate checker for a registered ao4 and-or block.
// Drives a..d, models y/q/r one cycle behind, and accumulates mismatch results.
module ao4_stim_checker #(
   parameter int          NUM_VECTORS = 64,
   parameter int          MODE        = 0,
   parameter logic [3:0]  SEED        = 4'hB,
   parameter int          ERR_W       = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   output logic             a,
   output logic             b,
   output logic             c,
   output logic             d,
   input  logic             y,
   input  logic             q,
   input  logic             r,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [ERR_W-1:0] err_count,
   output logic [15:0]      first_err_idx
);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

   localparam logic [3:0]  GEN_INIT = (MODE == 0) ? 4'h0 : SEED;
   localparam logic [15:0] LAST_IDX = 16'(NUM_VECTORS - 1);

   state_t           state_reg, state_next;
   logic [3:0]       vec_reg;
   logic [3:0]       gen_reg;
   logic [15:0]      idx_reg;
   logic             cmp_valid_reg;
   logic             cmp_y_reg;
   logic [15:0]      cmp_idx_reg;
   logic             exp_q_reg, exp_r_reg, exp_y_reg, exp_tmp2_reg, tmp2_known_reg;
   logic [ERR_W-1:0] err_count_reg;
   logic [15:0]      first_err_reg;

   logic start_run;
   logic last_vec;
   logic vec_t1;
   logic mismatch;

   function automatic logic [3:0] gen_step(input logic [3:0] v);
      if (MODE == 0)
         return v + 4'd1;
      else
         return {v[2:0], v[3] ^ v[2]};
   endfunction

   always_comb begin
      state_next = state_reg;
      start_run  = 1'b0;
      last_vec   = (idx_reg == LAST_IDX);
      case (state_reg)
         IDLE, DONE: begin
            if (start) begin
               start_run  = 1'b1;
               state_next = RUN;
            end
         end
         RUN:     if (last_vec) state_next = DRAIN;
         DRAIN:   state_next = DONE;
         default: state_next = IDLE;
      endcase
   end

   assign vec_t1 = vec_reg[3] & vec_reg[2];

   // y is only trusted once the block's unreset tmp2 has been written by a t1 vector
   assign mismatch = (q ^ exp_q_reg) | (r ^ exp_r_reg) | (cmp_y_reg & (y ^ exp_y_reg));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg      <= IDLE;
         vec_reg        <= 4'h0;
         gen_reg        <= 4'h0;
         idx_reg        <= 16'h0;
         cmp_valid_reg  <= 1'b0;
         cmp_y_reg      <= 1'b0;
         cmp_idx_reg    <= 16'h0;
         exp_q_reg      <= 1'b0;
         exp_r_reg      <= 1'b0;
         exp_y_reg      <= 1'b0;
         exp_tmp2_reg   <= 1'b0;
         tmp2_known_reg <= 1'b0;
         err_count_reg  <= '0;
         first_err_reg  <= 16'hFFFF;
      end else begin
         state_reg <= state_next;

         // The first vector goes out on the start edge so RUN cycle k shows vector k
         if (start_run) begin
            vec_reg <= GEN_INIT;
            gen_reg <= gen_step(GEN_INIT);
            idx_reg <= 16'h0;
         end else if (state_reg == RUN) begin
            if (last_vec) begin
               vec_reg <= 4'h0;
            end else begin
               vec_reg <= gen_reg;
               gen_reg <= gen_step(gen_reg);
               idx_reg <= idx_reg + 16'd1;
            end
         end

         if (state_reg == RUN) begin
            exp_q_reg     <= vec_reg[0];
            exp_r_reg     <= vec_reg[3] | vec_reg[2];
            exp_y_reg     <= vec_t1 | exp_tmp2_reg;
            cmp_valid_reg <= 1'b1;
            cmp_y_reg     <= vec_t1 | tmp2_known_reg;
            cmp_idx_reg   <= idx_reg;
            if (vec_t1) begin
               exp_tmp2_reg   <= vec_reg[1] & vec_reg[0];
               tmp2_known_reg <= 1'b1;
            end
         end else begin
            cmp_valid_reg <= 1'b0;
         end

         if (start_run) begin
            err_count_reg <= '0;
            first_err_reg <= 16'hFFFF;
         end else if (cmp_valid_reg && mismatch) begin
            if (err_count_reg != '1)
               err_count_reg <= err_count_reg + 1'b1;
            if (first_err_reg == 16'hFFFF)
               first_err_reg <= cmp_idx_reg;
         end
      end
   end

   assign {a, b, c, d}  = vec_reg;
   assign busy          = (state_reg == RUN) || (state_reg == DRAIN);
   assign done          = (state_reg == DONE);
   assign pass          = done && (err_count_reg == '0);
   assign err_count     = err_count_reg;
   assign first_err_idx = first_err_reg;

endmodule

// File: tb/tb_ao4_stim_checker.sv
// Bench for ao4_stim_checker: four checker instances each drive a behavioural ao4 block
// with selectable faults; scenario table, hand sequences and randomized fault injection.
module tb_ao4_stim_checker;

   localparam int N0 = 16, N1 = 15, N2 = 64, N3 = 1;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [3:0]  start = 4'h0;
   logic [3:0]  a_w, b_w, c_w, d_w;
   logic [3:0]  y_w, q_w, r_w;
   logic [3:0]  busy_w, done_w, pass_w;
   logic [7:0]  err0, err1, err3;
   logic [1:0]  err2;
   logic [15:0] first0, first1, first2, first3;

   int          fault [4];
   bit          rnd_on = 1'b0;
   logic [3:0]  tmp2;
   int          cnt1 = 255;
   logic [2:0]  flips [N1];
   bit          ref_seen;
   logic [3:0]  seen_vec [$];

   int          nvec = 0;
   int          nbad = 0;

   always #5 clk = ~clk;

   ao4_stim_checker #(.NUM_VECTORS(N0), .MODE(0), .SEED(4'hB), .ERR_W(8)) u0 (
      .clk(clk), .rst_n(rst_n), .start(start[0]),
      .a(a_w[0]), .b(b_w[0]), .c(c_w[0]), .d(d_w[0]),
      .y(y_w[0]), .q(q_w[0]), .r(r_w[0]),
      .busy(busy_w[0]), .done(done_w[0]), .pass(pass_w[0]),
      .err_count(err0), .first_err_idx(first0));

   ao4_stim_checker #(.NUM_VECTORS(N1), .MODE(1), .SEED(4'hB), .ERR_W(8)) u1 (
      .clk(clk), .rst_n(rst_n), .start(start[1]),
      .a(a_w[1]), .b(b_w[1]), .c(c_w[1]), .d(d_w[1]),
      .y(y_w[1]), .q(q_w[1]), .r(r_w[1]),
      .busy(busy_w[1]), .done(done_w[1]), .pass(pass_w[1]),
      .err_count(err1), .first_err_idx(first1));

   ao4_stim_checker #(.NUM_VECTORS(N2), .MODE(0), .SEED(4'hB), .ERR_W(2)) u2 (
      .clk(clk), .rst_n(rst_n), .start(start[2]),
      .a(a_w[2]), .b(b_w[2]), .c(c_w[2]), .d(d_w[2]),
      .y(y_w[2]), .q(q_w[2]), .r(r_w[2]),
      .busy(busy_w[2]), .done(done_w[2]), .pass(pass_w[2]),
      .err_count(err2), .first_err_idx(first2));

   ao4_stim_checker #(.NUM_VECTORS(N3), .MODE(0), .SEED(4'hB), .ERR_W(8)) u3 (
      .clk(clk), .rst_n(rst_n), .start(start[3]),
      .a(a_w[3]), .b(b_w[3]), .c(c_w[3]), .d(d_w[3]),
      .y(y_w[3]), .q(q_w[3]), .r(r_w[3]),
      .busy(busy_w[3]), .done(done_w[3]), .pass(pass_w[3]),
      .err_count(err3), .first_err_idx(first3));

   // ao4 blocks: fault 1 = y stuck 0, 2 = q inverted, 3 = r = a&b; instance 1 may get random flips
   initial tmp2 = 4'($urandom);

   always @(posedge clk) begin
      for (int i = 0; i < 4; i++) begin
         logic t1, yv, qv, rv;
         logic [2:0] m;
         t1 = a_w[i] & b_w[i];
         yv = t1 | tmp2[i];
         qv = d_w[i];
         rv = a_w[i] | b_w[i];
         case (fault[i])
            1:       yv = 1'b0;
            2:       qv = ~qv;
            3:       rv = a_w[i] & b_w[i];
            default: ;
         endcase
         if (i == 1 && rnd_on && cnt1 < N1) begin
            m = ($urandom_range(0, 2) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
            flips[cnt1] <= m;
            yv = yv ^ m[2];
            qv = qv ^ m[1];
            rv = rv ^ m[0];
         end
         y_w[i] <= yv;
         q_w[i] <= qv;
         r_w[i] <= rv;
         if (t1) tmp2[i] <= c_w[i] & d_w[i];
      end
      if (start[1]) cnt1 <= 0;
      else if (cnt1 < 255) cnt1 <= cnt1 + 1;
   end

   function automatic logic [7:0] errv(input int i);
      case (i)
         0:       return err0;
         1:       return err1;
         2:       return {6'd0, err2};
         default: return err3;
      endcase
   endfunction

   function automatic logic [15:0] firstv(input int i);
      case (i)
         0:       return first0;
         1:       return first1;
         2:       return first2;
         default: return first3;
      endcase
   endfunction

   function automatic logic [3:0] vecv(input int i);
      return {a_w[i], b_w[i], c_w[i], d_w[i]};
   endfunction

   function automatic logic [3:0] lfsr_nx(input logic [3:0] v);
      return 4'(((v << 1) & 4'hF) | (((v >> 3) ^ (v >> 2)) & 4'h1));
   endfunction

   // Expected k-th vector: plain count mod 16, or k LFSR steps from the seed
   function automatic logic [3:0] vec_ref(input int inst, input int k);
      logic [3:0] v;
      if (inst != 1) return 4'(k % 16);
      v = 4'hB;
      for (int j = 0; j < k; j++) v = lfsr_nx(v);
      return v;
   endfunction

   task automatic check(input string name, input int act, input int exp);
      nvec++;
      if (act != exp) begin
         nbad++;
         $display("FAIL %s: got %0d (0x%0h), want %0d (0x%0h)", name, act, act, exp, exp);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      ref_seen = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // Pulse start on one instance, record the vectors it drives, count edges until done
   task automatic run(input int i, input int nv, output int cyc);
      seen_vec.delete();
      @(negedge clk);
      start[i] = 1'b1;
      @(posedge clk);
      #1;
      start[i] = 1'b0;
      cyc = 1;
      while (!done_w[i] && cyc < 200) begin
         if (seen_vec.size() < nv) seen_vec.push_back(vecv(i));
         @(posedge clk);
         #1;
         cyc++;
      end
   endtask

   function automatic int seq_ok(input int inst, input int nv);
      int ok = 0;
      for (int k = 0; k < nv && k < seen_vec.size(); k++)
         if (seen_vec[k] == vec_ref(inst, k)) ok++;
      return ok;
   endfunction

   typedef struct {
      int inst;
      int flt;
      int nv;
      int exp_err;
      int exp_first;
      int exp_pass;
   } scen_t;

   scen_t tbl [4];

   initial begin
      int cyc, e, f;
      logic [3:0] v;
      logic t1, ycmp;

      tbl[0] = '{inst: 0, flt: 0, nv: N0, exp_err: 0,  exp_first: 16'hFFFF, exp_pass: 1};
      tbl[1] = '{inst: 0, flt: 1, nv: N0, exp_err: 4,  exp_first: 12,       exp_pass: 0};
      tbl[2] = '{inst: 1, flt: 2, nv: N1, exp_err: 15, exp_first: 0,        exp_pass: 0};
      tbl[3] = '{inst: 2, flt: 3, nv: N2, exp_err: 3,  exp_first: 4,        exp_pass: 0};
      for (int i = 0; i < 4; i++) fault[i] = 0;

      do_reset();
      #1;
      for (int i = 0; i < 4; i++) begin
         check("reset busy", int'(busy_w[i]), 0);
         check("reset done", int'(done_w[i]), 0);
         check("reset pass", int'(pass_w[i]), 0);
         check("reset err", int'(errv(i)), 0);
         check("reset first", int'(firstv(i)), 16'hFFFF);
         check("reset abcd", int'(vecv(i)), 0);
      end

      for (int s = 0; s < 4; s++) begin
         do_reset();
         fault[tbl[s].inst] = tbl[s].flt;
         run(tbl[s].inst, tbl[s].nv, cyc);
         $display("scenario %0d inst %0d fault %0d: cycles %0d err %0d first 0x%0h pass %0d",
                  s, tbl[s].inst, tbl[s].flt, cyc, errv(tbl[s].inst), firstv(tbl[s].inst),
                  pass_w[tbl[s].inst]);
         check("tbl cycles", cyc, tbl[s].nv + 2);
         check("tbl err", int'(errv(tbl[s].inst)), tbl[s].exp_err);
         check("tbl first", int'(firstv(tbl[s].inst)), tbl[s].exp_first);
         check("tbl pass", int'(pass_w[tbl[s].inst]), tbl[s].exp_pass);
         check("tbl vector seq", seq_ok(tbl[s].inst, tbl[s].nv), tbl[s].nv);
         fault[tbl[s].inst] = 0;
      end

      // Reset five cycles into a run, then a clean rerun
      @(negedge clk);
      start[0] = 1'b1;
      @(negedge clk);
      start[0] = 1'b0;
      repeat (4) @(negedge clk);
      rst_n = 1'b0;
      #1;
      $display("midrun reset: busy %0d done %0d err %0d first 0x%0h abcd 0x%0h",
               busy_w[0], done_w[0], err0, first0, vecv(0));
      check("midrun busy", int'(busy_w[0]), 0);
      check("midrun done", int'(done_w[0]), 0);
      check("midrun pass", int'(pass_w[0]), 0);
      check("midrun first", int'(first0), 16'hFFFF);
      check("midrun abcd", int'(vecv(0)), 0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      ref_seen = 1'b0;
      run(0, N0, cyc);
      $display("rerun after reset: cycles %0d err %0d pass %0d", cyc, err0, pass_w[0]);
      check("rerun cycles", cyc, N0 + 2);
      check("rerun pass", int'(pass_w[0]), 1);
      check("rerun first", int'(first0), 16'hFFFF);
      check("rerun seq", seq_ok(0, N0), N0);

      // NUM_VECTORS=1: start held into RUN is ignored; start in DONE restarts and clears
      do_reset();
      fault[3] = 2;
      @(negedge clk);
      start[3] = 1'b1;
      @(posedge clk);
      #1;
      check("n1 busy after start", int'(busy_w[3]), 1);
      @(posedge clk);
      #1;
      start[3] = 1'b0;
      check("n1 drain busy", int'(busy_w[3]), 1);
      check("n1 drain done", int'(done_w[3]), 0);
      @(posedge clk);
      #1;
      $display("n1 run: done %0d err %0d first 0x%0h", done_w[3], err3, first3);
      check("n1 done", int'(done_w[3]), 1);
      check("n1 err", int'(err3), 1);
      check("n1 first", int'(first3), 0);
      check("n1 pass", int'(pass_w[3]), 0);
      fault[3] = 0;
      run(3, N3, cyc);
      $display("n1 restart: cycles %0d err %0d pass %0d", cyc, err3, pass_w[3]);
      check("n1 restart cycles", cyc, 3);
      check("n1 restart err", int'(err3), 0);
      check("n1 restart first", int'(first3), 16'hFFFF);
      check("n1 restart pass", int'(pass_w[3]), 1);

      // Random bit flips on instance 1 scored by a vector-level reference
      do_reset();
      rnd_on = 1'b1;
      for (int n = 0; n < 8; n++) begin
         for (int k = 0; k < N1; k++) flips[k] = 3'd0;
         run(1, N1, cyc);
         e = 0;
         f = 16'hFFFF;
         for (int k = 0; k < N1; k++) begin
            v = vec_ref(1, k);
            t1 = v[3] & v[2];
            ycmp = t1 | ref_seen;
            if (t1) ref_seen = 1'b1;
            if (flips[k][1] | flips[k][0] | (flips[k][2] & ycmp)) begin
               e++;
               if (f == 16'hFFFF) f = k;
            end
         end
         $display("random run %0d: cycles %0d err %0d/%0d first 0x%0h/0x%0h",
                  n, cyc, err1, e, first1, f);
         check("rnd cycles", cyc, N1 + 2);
         check("rnd err", int'(err1), e);
         check("rnd first", int'(first1), f);
         check("rnd pass", int'(pass_w[1]), (e == 0) ? 1 : 0);
         check("rnd seq", seq_ok(1, N1), N1);
      end
      rnd_on = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
      $finish;
   end

endmodule

// File: doc/ao4_stim_checker.md
Name: ao4_stim_checker

Overview:
- Self-checking driver for the ao4-style registered and-or block (inputs a, b, c, d; registered outputs y, q, r). It sits on the opposite side of that block's interface.
- It generates input vectors on a, b, c, d and carries a cycle-accurate reference model of y, q and r.
- It compares the block's returned outputs against the model every cycle and reports a mismatch count, the first failing vector index and a pass flag.
- Used in unit benches and as an on-chip BIST wrapper.

Parameters:
- NUM_VECTORS, 64, vectors driven per run (1..65535).
- MODE, 0, 0 = 4-bit binary up-counter from 0; 1 = 4-bit LFSR.
- SEED, 4'hB, LFSR start value (MODE=1); must be nonzero.
- ERR_W, 8, width of err_count.

Ports:
- clk, input, 1, rising-edge clock.
- rst_n, input, 1, asynchronous active-low reset.
- start, input, 1, one-cycle pulse; begins a run when idle.
- a, output, 1, vector bit 3 to block under test.
- b, output, 1, vector bit 2.
- c, output, 1, vector bit 1.
- d, output, 1, vector bit 0.
- y, input, 1, block output y.
- q, input, 1, block output q.
- r, input, 1, block output r.
- busy, output, 1, high in RUN and DRAIN.
- done, output, 1, high in DONE.
- pass, output, 1, valid when done; 1 if err_count == 0.
- err_count, output, ERR_W, saturating mismatch count.
- first_err_idx, output, 16, index of first mismatching vector; 16'hFFFF if none.

Behaviour:
- Reset (async, rst_n low) values:
  - state = IDLE; a, b, c, d = 0; busy = 0; done = 0; pass = 0.
  - err_count = 0; first_err_idx = 16'hFFFF; vector index = 0.
  - Model registers exp_q = 0, exp_r = 0, exp_y = 0, exp_tmp2 = 0; tmp2_known = 0.
- States: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - On start=1: clear err_count and first_err_idx, load generator (0 or SEED), index = 0, go to RUN.
  - start is ignored in all other states.
- RUN:
  - Each cycle, drive {a,b,c,d} = generator value, registered.
  - Advance generator; index increments.
  - After vector NUM_VECTORS-1 is driven, go to DRAIN.
- Generator rules:
  - Counter mode wraps 15 -> 0.
  - LFSR is x^4+x^3+1, shift left, feedback bit0 = bit3 ^ bit2. It never produces 4'h0.
- Model update: on each edge where a vector is on a..d (the same edge the block samples it), let t1 = a & b. Then:
  - exp_q <= d.
  - exp_r <= a | b.
  - exp_y <= t1 | exp_tmp2, using the old exp_tmp2.
  - If t1: exp_tmp2 <= c & d and tmp2_known <= 1.
- Compare:
  - Active on the cycle after each vector is sampled, i.e. 1-cycle latency from drive to compare.
  - q and r are always compared.
  - y is compared only when t1 was 1 for that vector, or tmp2_known was already 1 before it. This masks the block's unreset tmp2.
  - A mismatch on any compared bit counts once per vector.
  - err_count increments and saturates at all-ones.
  - If first_err_idx == 16'hFFFF, it takes the index of the failing vector.
- DRAIN:
  - One cycle performing the compare for the last vector.
  - a..d return to 0 and are not compared. Then go to DONE.
- DONE:
  - done = 1; pass = (err_count == 0).
  - Outputs hold until the next start, which re-enters RUN directly (same clear actions as from IDLE).
- Reset mid-run aborts immediately to IDLE with reset values; no partial results are kept.
- NUM_VECTORS = 1: RUN lasts exactly one cycle, then DRAIN, then DONE.
- busy-to-done timing: total cycles from start to done = NUM_VECTORS + 2.

Test Plan:
- Correct ao4 model as block, MODE=0, NUM_VECTORS=16, start pulse -> done after 18 cycles, pass=1, err_count=0, first_err_idx=16'hFFFF; a..d sequence 0..15.
- Block with y stuck at 0, MODE=0, NUM_VECTORS=16 -> first compared y=1 case is vector 12 (a=b=1, c=d=0) -> first_err_idx=12, err_count=4, pass=0.
- Block with q inverted, MODE=1, SEED=4'hB, NUM_VECTORS=15 -> err_count=15, first_err_idx=0; a..d sequence starts B,7,F,E.
- Block with r = a & b, ERR_W=2, NUM_VECTORS=64, MODE=0 -> err_count saturates at 3, pass=0.
- rst_n asserted 5 cycles into a run, then released -> all outputs at reset values, state IDLE; a new start gives a clean full run with pass=1.
- start pulsed during RUN and again in DONE, NUM_VECTORS=1 -> first ignored; second restarts, done re-asserted 3 cycles later; err_count cleared on restart.
